// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : op-code and FSM state types shared by the ALU slice        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8
  } alu_op_e;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mul_seq : iterative shift-add multiplier, WIDTH iterations       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  // Product is the accumulator after the final iteration, so it is valid on the done edge.
  assign done       = r_busy && (r_cnt == C_LAST);
  assign product    = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= a;
      r_mplr  <= b;
      r_acc   <= '0;
    end else if (r_busy) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_unit : handshaked ALU with registered result/flags, seq. MUL     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  alu_op_e          w_op;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_ovf;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;

  assign w_op     = alu_op_e'(op);
  assign w_is_mul = (w_op == OP_MUL);
  assign in_ready = (r_state == IDLE) && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_accept && w_is_mul),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  // SUB is a + ~b + 1, so the ADD overflow rule applies against the inverted operand.
  assign w_sub   = (w_op == OP_SUB);
  assign w_b_eff = w_sub ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOT:  w_res = ~a;
      OP_SLL:  w_res = a << b[SHW-1:0];
      OP_SRL:  w_res = a >> b[SHW-1:0];
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_mul) w_state_next = MUL_RUN;
      MUL_RUN: if (w_mul_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_valid  <= 1'b1;
      r_result <= w_res;
      r_cout   <= w_cout;
      r_ovf    <= w_ovf;
      r_zero   <= (w_res == '0);
      r_neg    <= w_res[WIDTH-1];
    end else if (w_mul_done) begin
      r_valid  <= 1'b1;
      r_result <= w_mul_product;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= (w_mul_product == '0);
      r_neg    <= w_mul_product[WIDTH-1];
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign result    = r_result;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;

endmodule
`default_nettype wire

// File: doc/alu_unit.md
# alu_unit

Parametrised, handshaked ALU that supersedes the fixed 32-bit add/NOT datapath. It accepts one operation per transfer on a valid/ready input port and returns a registered result plus status flags on a valid/ready output port. Single-cycle ops sustain one result per clock. MUL runs as an iterative shift-add over WIDTH cycles. The block sits between the register-file read stage and the register write-back stage.

## Interface
- `WIDTH`, default 32: operand/result width, ≥ 4, power of two.
- `SHW`, default $clog2(WIDTH): shift-amount bits taken from `b[SHW-1:0]`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `in_valid`  in  1: operand/op presented.
- `in_ready`  out  1: block can accept this cycle.
- `op`  in  4: operation code (see Operation).
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `out_valid`  out  1: result register holds an unconsumed result.
- `out_ready`  in  1: consumer takes the result this cycle.
- `result`  out  WIDTH: registered result.
- `cout`  out  1: carry (ADD) / no-borrow (SUB), else 0.
- `ovf`  out  1: signed overflow (ADD/SUB), else 0.
- `zero`  out  1: `result == 0`.
- `neg`  out  1: `result[WIDTH-1]`.

## Operation
- Op codes:
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~a
  - 6 SLL: a << b[SHW-1:0]
  - 7 SRL: logical shift
  - 8 MUL: low WIDTH bits of a×b, unsigned
  - 9–15 illegal: result 0, cout=ovf=0, zero=1, neg=0
- Arithmetic: ADD/SUB computed at WIDTH+1 bits. cout = bit WIDTH for ADD and for a+~b+1 on SUB (1 ⇔ a ≥ b unsigned). ovf = operand sign bits agree (ADD), or differ (SUB), and the result sign differs from a's sign.
- FSM states:
  - IDLE: accepts any op.
  - MUL_RUN: counter 0..WIDTH−1; multiplicand shifts left, multiplier shifts right, accumulate when the multiplier LSB = 1.
- Transitions:
  - IDLE→MUL_RUN on accepting op 8.
  - MUL_RUN→IDLE when the counter reaches WIDTH−1; the accumulator loads into the output register on that edge with out_valid=1.
  - Every other accepted op stays in IDLE and loads the output register directly.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
- Transfer occurs when `in_valid && in_ready`; `op`, `a`, `b` are sampled only then.
- Output handshake: out_valid and all output data/flags are held stable until `out_valid && out_ready`.
  - Consume without a new load: out_valid→0; result/flags keep their last value.
- Simultaneous consume and accept (single-cycle op): the new result loads on the same edge and out_valid stays 1, giving full throughput.
- During MUL_RUN, in_ready=0 and out_valid=0; `in_valid` is ignored.
- Reset (async, any state, including mid-MUL): state=IDLE, counter=0, accumulator=0, out_valid=0, result=0, cout=ovf=neg=0, zero=0. in_ready=1 while rst_n low and after release. An aborted MUL produces no output.

## Timing
- Single-cycle op accepted at edge N: out_valid=1 with result after edge N (latency 1). Throughput is 1/cycle while out_ready=1.
- MUL accepted at edge N: out_valid=1 after edge N+WIDTH. in_ready is low from after edge N until the output is consumed.
- Flags are registered with result; there is no combinational in→out path except in_ready←out_ready.
- out_ready low while out_valid=1 stalls input (in_ready=0) with no data loss.

## Structure
- Package `alu_pkg`: `alu_op_e` (4-bit op enum above), `alu_state_e` {IDLE, MUL_RUN}, and the op-code constants shared with the decoder.
- Sub-module `alu_mul_seq #(WIDTH)`:
  - Inputs: start, a, b.
  - Outputs: done (1-cycle pulse), product[WIDTH-1:0].
  - Owns the counter and accumulator.
- The top holds the combinational single-cycle datapath, the FSM, the output register and the handshake logic.

## Test plan
- Reset mid-MUL: start MUL 7×9, assert rst_n=0 at cycle 5 → outputs all zero, out_valid=0, in_ready=1; no later result appears.
- ADD overflow (WIDTH=32): a=0x7FFFFFFF, b=1 → result 0x80000000, ovf=1, neg=1, cout=0, zero=0, one cycle after accept.
- SUB borrow: a=3, b=5 → result 0xFFFFFFFE, cout=0, neg=1. Then a=5, b=5 → result 0, zero=1, cout=1.
- Back-to-back with out_ready=1: XOR, NOT a=0, SLL a=1 b=31 over 3 consecutive cycles → results 0x…, 0xFFFFFFFF, 0x80000000 on consecutive cycles. in_ready stays 1.
- MUL latency and stall: 0xFFFF×0x10001 with out_ready=0 → out_valid rises exactly 32 cycles after accept, result 0xFFFFFFFF. Output held and in_ready=0 until out_ready=1.
- Illegal op 12 and SRL a=0x80000000 b=35 (shift amount 3) → 0/zero=1, then 0x10000000.
